// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and
// writes them sequentially into instruction memory from word address 0.
// busy holds the core in reset while a load is in progress.
module imem_loader #(
    parameter int DEPTH     = 256,
    parameter int ADR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADR_WIDTH:0]   word_count,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [31:0]          wr_addr,
    output logic [31:0]          wr_din,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADR_WIDTH:0] DEPTH_W = (ADR_WIDTH + 1)'(DEPTH);

    state_t               state, state_nxt;
    logic [ADR_WIDTH:0]   count_q;     // words requested for this load
    logic [ADR_WIDTH:0]   words_done;  // completed words; also the next word index
    logic [1:0]           byte_idx;    // position of the next byte within the word
    logic [23:0]          word_buf;    // lower three bytes of the word being built

    logic start_ok;
    logic start_bad;
    logic accept;

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and combinational outputs.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        accept    = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0 && word_count <= DEPTH_W) begin
                        start_ok  = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = (words_done < count_q);
                if (abort) begin
                    // Partial word and any unissued write are dropped.
                    state_nxt = IDLE;
                end else begin
                    accept = in_valid && in_ready;
                    // All words accepted: this is the cycle of the final write.
                    if (words_done == count_q) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Byte assembly, word counting and registered write/err outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            words_done <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_din     <= '0;
            err        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            err   <= start_bad;

            if (start_ok) begin
                count_q    <= word_count;
                words_done <= '0;
                byte_idx   <= '0;
            end

            if (state == LOAD && abort) begin
                byte_idx <= '0;
            end

            if (accept) begin
                if (byte_idx == 2'd3) begin
                    // Fourth byte completes the word; write it next cycle
                    // while the stream keeps flowing into the following word.
                    wr_en      <= 1'b1;
                    wr_addr    <= {{(30 - ADR_WIDTH){1'b0}}, words_done[ADR_WIDTH-1:0], 2'b00};
                    wr_din     <= {in_data, word_buf};
                    words_done <= words_done + 1'b1;
                    byte_idx   <= '0;
                end else begin
                    // Shift in from the top so byte 0 ends in bits [7:0].
                    word_buf <= {in_data, word_buf[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are queued
// when a load is set up and compared by a monitor whenever wr_en is seen.
module tb_imem_loader;

    localparam int DEPTH     = 256;
    localparam int ADR_WIDTH = $clog2(DEPTH);

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [ADR_WIDTH:0]   word_count;
    logic                 abort;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 wr_en;
    logic [31:0]          wr_addr;
    logic [31:0]          wr_din;
    logic                 busy;
    logic                 done;
    logic                 err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    int          checks    = 0;
    int          failures  = 0;
    int          wr_cnt    = 0;
    int          done_cnt  = 0;
    logic [31:0] last_addr = '0;

    imem_loader #(.DEPTH(DEPTH), .ADR_WIDTH(ADR_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_din     (wr_din),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Write/done monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                last_addr = wr_addr;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {31'b0, wr_en}, 32'd0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", wr_addr, exp_e.addr);
                    check("wr_data", wr_din, exp_e.data);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr: addr, data: data});
    endtask

    task automatic do_start(input int wc);
        start      = 1'b1;
        word_count = (ADR_WIDTH + 1)'(wc);
        step();
        start      = 1'b0;
    endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic send_byte(input logic [7:0] b);
        int ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        if (ok == 1) step();
        else check("byte_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            step();
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        step();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int w0, d0;
        logic [31:0] w;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;

        // Reset state
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_wr_en",    {31'b0, wr_en},    32'd0);
        check("rst_busy",     {31'b0, busy},     32'd0);
        check("rst_done",     {31'b0, done},     32'd0);
        check("rst_err",      {31'b0, err},      32'd0);
        check("rst_wr_addr",  wr_addr,           32'd0);
        check("rst_wr_din",   wr_din,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Normal continuous load of two words, with an ignored start mid-load
        push_wr(32'h0, 32'h0000_0013);
        push_wr(32'h4, 32'h0010_0093);
        do_start(2);
        check("norm_busy", {31'b0, busy}, 32'd1);
        start = 1'b1; word_count = 9'd1;
        step();
        start = 1'b0;
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        check("norm_ready_off", {31'b0, in_ready}, 32'd0);
        wait_done("norm");
        check("norm_wr_cnt", 32'(wr_cnt), 32'd2);

        // Gapped stream: in_valid every other cycle
        push_wr(32'h0, 32'hDEAD_BEEF);
        do_start(1);
        send_byte(8'hEF); step();
        send_byte(8'hBE); step();
        send_byte(8'hAD); step();
        send_byte(8'hDE);
        check("gap_wr_en",  {31'b0, wr_en}, 32'd1);
        check("gap_wr_din", wr_din, 32'hDEAD_BEEF);
        wait_done("gap");

        // Rejected starts
        w0 = wr_cnt;
        do_start(0);
        check("rej0_err",  {31'b0, err},  32'd1);
        check("rej0_busy", {31'b0, busy}, 32'd0);
        step();
        check("rej0_err_pulse", {31'b0, err}, 32'd0);
        do_start(257);
        check("rej257_err",  {31'b0, err},  32'd1);
        check("rej257_busy", {31'b0, busy}, 32'd0);
        step();
        check("rej257_err_pulse", {31'b0, err}, 32'd0);
        check("rej_no_write", 32'(wr_cnt), 32'(w0));

        // Abort after 6 of 8 bytes, then reload from address 0
        w0 = wr_cnt;
        d0 = done_cnt;
        push_wr(32'h0, 32'h0403_0201);
        do_start(2);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy",  {31'b0, busy},     32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) step();
        check("abort_wr_cnt", 32'(wr_cnt - w0), 32'd1);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        push_wr(32'h0, 32'h4433_2211);
        do_start(1);
        send_word(32'h4433_2211);
        wait_done("reload");

        // Abort coinciding with the fourth byte: no write
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(1);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        abort    = 1'b1;
        step();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("coin_wr_en", {31'b0, wr_en}, 32'd0);
        check("coin_busy",  {31'b0, busy},  32'd0);
        repeat (3) step();
        check("coin_wr_cnt",  32'(wr_cnt),   32'(w0));
        check("coin_no_done", 32'(done_cnt), 32'(d0));

        // Full-depth load
        w0 = wr_cnt;
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            push_wr(32'(i) * 32'd4, w);
            send_word(w);
        end
        check("full_ready_off", {31'b0, in_ready}, 32'd0);
        wait_done("full");
        check("full_wr_cnt", 32'(wr_cnt - w0), 32'(DEPTH));
        check("full_last_addr", last_addr, 32'h0000_03FC);

        // Asynchronous reset mid-load
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        in_valid = 1'b1;
        in_data  = 8'h04;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'b0, in_ready}, 32'd0);
        check("arst_wr_en",    {31'b0, wr_en},    32'd0);
        check("arst_busy",     {31'b0, busy},     32'd0);
        check("arst_done",     {31'b0, done},     32'd0);
        check("arst_err",      {31'b0, err},      32'd0);
        check("arst_wr_addr",  wr_addr,           32'd0);
        check("arst_wr_din",   wr_din,            32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        check("arst_busy_after", {31'b0, busy}, 32'd0);
        check("arst_no_write", 32'(wr_cnt),   32'(w0));
        check("arst_no_done",  32'(done_cnt), 32'(d0));

        // Fresh load after reset starts at address 0
        push_wr(32'h0, 32'h1234_5678);
        do_start(1);
        send_word(32'h1234_5678);
        wait_done("post_rst");

        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
